// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forward-select encodings and the hazard tag entries
// tracked for the EX, MEM and WB stages.
package pipeline_pkg;

    // Register specifiers are stored zero-extended to this width; REG_BITS must not exceed it.
    localparam int PIPE_REG_BITS = 8;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                     valid;
        logic                     reg_write;
        logic                     mem_read;
        logic [PIPE_REG_BITS-1:0] write_reg;
    } tag_entry_t;

    typedef struct packed {
        tag_entry_t               tag;
        logic [PIPE_REG_BITS-1:0] rs;
        logic [PIPE_REG_BITS-1:0] rt;
    } ex_entry_t;

    // True when the stage holding this tag will produce a usable value for register r.
    function automatic logic tag_supplies(input tag_entry_t t, input logic [PIPE_REG_BITS-1:0] r);
        return t.valid && t.reg_write && (t.write_reg != '0) && (t.write_reg == r);
    endfunction

endpackage

// File: rtl/forward_select.sv
// Forwarding mux select for one EX operand: the youngest producer (MEM) wins over WB,
// and register 0 is never forwarded.
module forward_select
    import pipeline_pkg::*;
(
    input  logic                     ex_valid,
    input  logic [PIPE_REG_BITS-1:0] src_reg,
    input  tag_entry_t               mem_tag,
    input  tag_entry_t               wb_tag,
    output fwd_sel_e                 sel
);

    // Load flags only matter for the load-use stall, not for selecting a bypass source.
    logic unused_load_flags;
    assign unused_load_flags = mem_tag.mem_read ^ wb_tag.mem_read;

    always_comb begin
        sel = FWD_REG;
        if (ex_valid) begin
            if (tag_supplies(mem_tag, src_reg)) begin
                sel = FWD_MEM;
            end else if (tag_supplies(wb_tag, src_reg)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding for a five-stage pipeline: tracks EX/MEM/WB tags,
// raises load-use stalls and branch flushes, and counts both with saturating counters.
module hazard_forward_unit
    import pipeline_pkg::*;
#(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ID_Valid,
    input  logic [REG_BITS-1:0] ID_Rs,
    input  logic [REG_BITS-1:0] ID_Rt,
    input  logic [REG_BITS-1:0] ID_WriteReg,
    input  logic                ID_RegWrite,
    input  logic                ID_MemRead,
    input  logic                BranchTaken,
    output logic [1:0]          ForwardA,
    output logic [1:0]          ForwardB,
    output logic                Stall,
    output logic                FlushIFID,
    output logic                FlushIDEX,
    output logic [CNT_BITS-1:0] StallCount,
    output logic [CNT_BITS-1:0] FlushCount
);

    ex_entry_t  ex_q;
    tag_entry_t mem_q;
    tag_entry_t wb_q;

    logic [PIPE_REG_BITS-1:0] id_rs;
    logic [PIPE_REG_BITS-1:0] id_rt;
    logic [PIPE_REG_BITS-1:0] id_wr;
    logic                     load_use;
    fwd_sel_e                 fwd_a;
    fwd_sel_e                 fwd_b;

    assign id_rs = PIPE_REG_BITS'(ID_Rs);
    assign id_rt = PIPE_REG_BITS'(ID_Rt);
    assign id_wr = PIPE_REG_BITS'(ID_WriteReg);

    // A taken branch squashes the dependent instruction anyway, so it overrides the stall.
    always_comb begin
        load_use = ex_q.tag.valid && ex_q.tag.mem_read && (ex_q.tag.write_reg != '0) &&
                   ID_Valid && ((ex_q.tag.write_reg == id_rs) || (ex_q.tag.write_reg == id_rt));
        Stall     = load_use && !BranchTaken;
        FlushIFID = BranchTaken;
        FlushIDEX = BranchTaken;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q.tag;
            if (Stall || BranchTaken) begin
                ex_q <= '0;
            end else begin
                ex_q.tag.valid     <= ID_Valid;
                ex_q.tag.reg_write <= ID_RegWrite;
                ex_q.tag.mem_read  <= ID_MemRead;
                ex_q.tag.write_reg <= id_wr;
                ex_q.rs            <= id_rs;
                ex_q.rt            <= id_rt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (Stall && (StallCount != '1)) begin
                StallCount <= StallCount + CNT_BITS'(1);
            end
            if (BranchTaken && (FlushCount != '1)) begin
                FlushCount <= FlushCount + CNT_BITS'(1);
            end
        end
    end

    forward_select u_fwd_a (
        .ex_valid (ex_q.tag.valid),
        .src_reg  (ex_q.rs),
        .mem_tag  (mem_q),
        .wb_tag   (wb_q),
        .sel      (fwd_a)
    );

    forward_select u_fwd_b (
        .ex_valid (ex_q.tag.valid),
        .src_reg  (ex_q.rt),
        .mem_tag  (mem_q),
        .wb_tag   (wb_q),
        .sel      (fwd_b)
    );

    assign ForwardA = fwd_a;
    assign ForwardB = fwd_b;

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter REG_BITS, default 5, register-specifier width.
REQ-002 SHALL have parameter CNT_BITS, default 16, performance-counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ID_Valid  input  1  a real instruction occupies ID.
REQ-006 SHALL have port ID_Rs  input  REG_BITS  first source register of the ID instruction.
REQ-007 SHALL have port ID_Rt  input  REG_BITS  second source register of the ID instruction.
REQ-008 SHALL have port ID_WriteReg  input  REG_BITS  destination register of the ID instruction.
REQ-009 SHALL have port ID_RegWrite  input  1  ID instruction writes the register file.
REQ-010 SHALL have port ID_MemRead  input  1  ID instruction is a load.
REQ-011 SHALL have port BranchTaken  input  1  branch resolved taken by the instruction in EX.
REQ-012 SHALL have port ForwardA  output  2  EX operand-1 select: 00 regfile, 01 WB, 10 MEM.
REQ-013 SHALL have port ForwardB  output  2  EX operand-2 select, same encoding as ForwardA.
REQ-014 SHALL have port Stall  output  1  hold PC and IF/ID this cycle.
REQ-015 SHALL have port FlushIFID  output  1  squash the IF/ID register.
REQ-016 SHALL have port FlushIDEX  output  1  squash the ID/EX register.
REQ-017 SHALL have port StallCount  output  CNT_BITS  saturating count of stall cycles.
REQ-018 SHALL have port FlushCount  output  CNT_BITS  saturating count of flush events.

Function
REQ-019 SHALL keep a three-entry tag pipeline (EX, MEM, WB); each entry holds valid, RegWrite, MemRead, WriteReg; the EX entry also holds Rs and Rt.
REQ-020 SHALL advance every cycle: WB<=MEM, MEM<=EX, EX<=ID fields (valid=ID_Valid) when neither Stall nor BranchTaken is asserted.
REQ-021 SHALL load a bubble into EX (valid=0, RegWrite=0, MemRead=0) on a Stall or BranchTaken cycle; MEM and WB still advance.
REQ-022 SHALL assert Stall combinationally when the EX entry is valid, MemRead=1, WriteReg!=0, ID_Valid=1, and WriteReg equals ID_Rs or ID_Rt (load-use), giving exactly a one-cycle stall per load-use pair.
REQ-023 SHALL assert FlushIFID and FlushIDEX combinationally while BranchTaken=1.
REQ-024 SHALL give BranchTaken priority over load-use: when both hold, Stall=0 and the flush outputs are 1.
REQ-025 SHALL drive ForwardA=10 when the MEM entry is valid, RegWrite=1, WriteReg!=0, and WriteReg==EX.Rs; else 01 on the same test against WB; else 00.
REQ-026 SHALL drive ForwardB by the REQ-025 rule using EX.Rt.
REQ-027 SHALL give MEM priority over WB when both match.
REQ-028 SHALL never forward register 0.
REQ-029 SHALL drive ForwardA/ForwardB as 00 when the EX entry is invalid.
REQ-030 SHALL derive ForwardA/ForwardB from registered tags only; a change on the ID_* inputs SHALL affect them only after the next edge.
REQ-031 SHALL increment StallCount on each rising edge at which Stall=1, and FlushCount on each edge at which BranchTaken=1.
REQ-032 SHALL saturate both counters at all-ones without wrapping.

Reset
REQ-033 SHALL, while rst_n=0, clear all tag entries to invalid/zero and both counters to 0, independent of clk.
REQ-034 SHALL hold ForwardA=ForwardB=00 and Stall=FlushIFID=FlushIDEX=0 during reset, except that the flush outputs follow BranchTaken combinationally.
REQ-035 SHALL, on reset asserted mid-stall, discard the pending stall; the first post-reset cycle sees an empty pipeline.

Structure
REQ-036 SHALL place the forward-select encodings (FWD_REG=00, FWD_WB=01, FWD_MEM=10) and the tag-entry struct in shared package pipeline_pkg, also used by the EX stage.
REQ-037 SHALL instantiate one sub-module, forward_select, once per operand, to compute the REQ-025 priority compare.

Verification
REQ-038 SHALL check: add $3 followed immediately by sub using $3 as Rs -> ForwardA=10 on the sub's EX cycle; one unrelated instruction between them -> ForwardA=01.
REQ-039 SHALL check: lw $4 followed by add using $4 as Rt -> Stall=1 for exactly one cycle, EX bubble, then ForwardB=01, StallCount=1.
REQ-040 SHALL check: an instruction writing $0 followed by a reader of $0 -> ForwardA=ForwardB=00.
REQ-041 SHALL check: MEM and WB both writing $5 with EX reading $5 -> ForwardA=10.
REQ-042 SHALL check: BranchTaken=1 coincident with a load-use condition -> FlushIFID=FlushIDEX=1, Stall=0, FlushCount+1, StallCount unchanged.
REQ-043 SHALL check: rst_n pulsed low mid-stall -> all outputs 0, counters 0 immediately; with the counter preset near full, 2^CNT_BITS+5 stall cycles -> StallCount holds at all-ones.
